// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The master side is the FSM; the slave side is the datapath and ALU decoder.
interface multicycle_control_fsm_if #(
  parameter int unsigned RET_CNT_W = 32
);
  logic [5:0]           opcode;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_en;
  logic                 iord;
  logic                 ir_write;
  logic                 mem_write;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 reg_dst;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           pc_src;
  logic [1:0]           alu_op;
  logic                 illegal_op;
  logic [3:0]           state_dbg;
  logic [RET_CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, ir_write, mem_write, reg_write, mem_to_reg, reg_dst, alu_src_a,
           alu_src_b, pc_src, alu_op, illegal_op, state_dbg, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, ir_write, mem_write, reg_write, mem_to_reg, reg_dst, alu_src_a,
           alu_src_b, pc_src, alu_op, illegal_op, state_dbg, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional macro CTRL_BNE_EN adds a bne state (12) branching on ~zero.
module multicycle_control_fsm #(
  parameter int unsigned RET_CNT_W   = 32,
  parameter bit          USE_MEM_RDY = 1'b1
) (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StBne    = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e               state_q, state_d;
  logic [RET_CNT_W-1:0] retired_q, retired_d;

  logic       rdy;
  logic       pc_write, branch, branch_ne, terminal;
  logic       iord, ir_write, mem_write, reg_write, mem_to_reg, reg_dst, alu_src_a;
  logic       illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;

  assign rdy = USE_MEM_RDY ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d    = StFetch;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    terminal   = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    illegal_op = 1'b0;

    unique case (state_q)
      StFetch: begin
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        state_d   = rdy ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        unique case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef CTRL_BNE_EN
          OpBne:      state_d = StBne;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.opcode == OpLw) begin
          state_d = StMemRd;
        end else if (bus.opcode == OpSw) begin
          state_d = StMemWr;
        end
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = rdy ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        terminal   = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        terminal  = 1'b1;
        state_d   = rdy ? StFetch : StMemWr;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        terminal  = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        terminal  = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        terminal  = 1'b1;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        terminal = 1'b1;
      end
`ifdef CTRL_BNE_EN
      StBne: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch_ne = 1'b1;
        terminal  = 1'b1;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  // Count only completed instructions; an illegal decode returns to fetch uncounted.
  assign retired_d = (terminal && (state_d == StFetch)) ? retired_q + 1'b1 : retired_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are forced low while reset is held so no enable leaks out of FETCH.
  assign bus.pc_en      = reset_n & (pc_write | (branch & bus.zero) | (branch_ne & ~bus.zero));
  assign bus.iord       = reset_n & iord;
  assign bus.ir_write   = reset_n & ir_write;
  assign bus.mem_write  = reset_n & mem_write;
  assign bus.reg_write  = reset_n & reg_write;
  assign bus.mem_to_reg = reset_n & mem_to_reg;
  assign bus.reg_dst    = reset_n & reg_dst;
  assign bus.alu_src_a  = reset_n & alu_src_a;
  assign bus.alu_src_b  = reset_n ? alu_src_b : 2'b00;
  assign bus.pc_src     = reset_n ? pc_src : 2'b00;
  assign bus.alu_op     = reset_n ? alu_op : 2'b00;
  assign bus.illegal_op = reset_n & illegal_op;
  assign bus.state_dbg  = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scoreboard bench for multicycle_control_fsm.
// Expected control vectors are queued as stimulus is driven and checked at the falling edge.
module tb_multicycle_control_fsm;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic [31:0] ret;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_ret = '0;
  exp_t sb[$];

  multicycle_control_fsm_if #(.RET_CNT_W(32)) bus ();

  multicycle_control_fsm #(.RET_CNT_W(32), .USE_MEM_RDY(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [14:0] obs_ctrl;
  assign obs_ctrl = {bus.pc_en, bus.iord, bus.ir_write, bus.mem_write, bus.reg_write,
                     bus.mem_to_reg, bus.reg_dst, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                     bus.alu_op, bus.illegal_op};

  // Reference decode of the control outputs from the expected state and inputs.
  function automatic logic [14:0] model(input int st, input logic [5:0] op, input logic z,
                                        input logic rdy, input logic rn);
    logic pcw, br, brn, iord, irw, mw, rw, m2r, rd, sa, ill;
    logic [1:0] sb_, ps, ao;
    {pcw, br, brn, iord, irw, mw, rw, m2r, rd, sa, ill} = '0;
    sb_ = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      0:  begin irw = rdy; pcw = rdy; sb_ = 2'b01; end
      1:  begin
            sb_ = 2'b11;
            ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                               6'b000010
`ifdef CTRL_BNE_EN
                               , 6'b000101
`endif
                               });
          end
      2:  begin sa = 1'b1; sb_ = 2'b10; end
      3:  iord = 1'b1;
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin iord = 1'b1; mw = 1'b1; end
      6:  begin sa = 1'b1; ao = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      9:  begin sa = 1'b1; sb_ = 2'b10; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pcw = 1'b1; end
      12: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; brn = 1'b1; end
      default: ;
    endcase
    if (!rn) return '0;
    return {pcw | (br & z) | (brn & ~z), iord, irw, mw, rw, m2r, rd, sa, sb_, ps, ao, ill};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive mem_ready, queue the expectation, compare at negedge.
  task automatic step(input string tag, input int st, input logic rdy, input bit done);
    exp_t e, g;
    bus.mem_ready = rdy;
    e.st   = st[3:0];
    e.ctrl = model(st, bus.opcode, bus.zero, rdy, reset_n);
    e.ret  = exp_ret;
    e.tag  = tag;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    check_vec({g.tag, ".state"}, {28'd0, bus.state_dbg}, {28'd0, g.st});
    check_vec({g.tag, ".ctrl"}, {17'd0, obs_ctrl}, {17'd0, g.ctrl});
    check_vec({g.tag, ".retired"}, bus.retired, g.ret);
    @(posedge clk);
    #1;
    if (done) exp_ret++;
  endtask

  initial begin
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) step("reset", 0, 1'b1, 1'b0);
    reset_n = 1'b1;
    step("fetch_after_reset", 0, 1'b1, 1'b0);
    step("rtype_decode", 1, 1'b1, 1'b0);
    step("rtype_exec", 6, 1'b1, 1'b0);
    step("rtype_aluwb", 7, 1'b1, 1'b1);

    bus.opcode = 6'b100011;
    step("lw_fetch_stall", 0, 1'b0, 1'b0);
    step("lw_fetch", 0, 1'b1, 1'b0);
    step("lw_decode", 1, 1'b1, 1'b0);
    step("lw_memadr", 2, 1'b1, 1'b0);
    step("lw_memrd_wait0", 3, 1'b0, 1'b0);
    step("lw_memrd_wait1", 3, 1'b0, 1'b0);
    step("lw_memrd", 3, 1'b1, 1'b0);
    step("lw_memwb", 4, 1'b1, 1'b1);

    bus.opcode = 6'b101011;
    step("sw_fetch", 0, 1'b1, 1'b0);
    step("sw_decode", 1, 1'b1, 1'b0);
    step("sw_memadr", 2, 1'b1, 1'b0);
    step("sw_memwr_wait0", 5, 1'b0, 1'b0);
    step("sw_memwr_wait1", 5, 1'b0, 1'b0);
    step("sw_memwr", 5, 1'b1, 1'b1);

    for (int z = 1; z >= 0; z--) begin
      bus.opcode = 6'b000100;
      bus.zero   = z[0];
      step("beq_fetch", 0, 1'b1, 1'b0);
      step("beq_decode", 1, 1'b1, 1'b0);
      step(z[0] ? "beq_taken" : "beq_not_taken", 8, 1'b1, 1'b1);
    end

    bus.opcode = 6'b000010;
    step("j_fetch", 0, 1'b1, 1'b0);
    step("j_decode", 1, 1'b1, 1'b0);
    step("j_jump", 11, 1'b1, 1'b1);

    bus.opcode = 6'b001000;
    step("addi_fetch", 0, 1'b1, 1'b0);
    step("addi_decode", 1, 1'b1, 1'b0);
    step("addi_ex", 9, 1'b1, 1'b0);
    step("addi_wb", 10, 1'b1, 1'b1);

    bus.opcode = 6'b111111;
    step("illegal_fetch", 0, 1'b1, 1'b0);
    step("illegal_decode", 1, 1'b1, 1'b0);

    for (int z = 0; z < 2; z++) begin
      bus.opcode = 6'b000101;
      bus.zero   = z[0];
      step("bne_fetch", 0, 1'b1, 1'b0);
      step("bne_decode", 1, 1'b1, 1'b0);
`ifdef CTRL_BNE_EN
      step("bne_branch", 12, 1'b1, 1'b1);
`endif
    end

    // Asynchronous reset while a store is stalled in MEMWR.
    bus.opcode = 6'b101011;
    step("rst_sw_fetch", 0, 1'b1, 1'b0);
    step("rst_sw_decode", 1, 1'b1, 1'b0);
    step("rst_sw_memadr", 2, 1'b1, 1'b0);
    bus.mem_ready = 1'b0;
    #2;
    check_vec("memwr_before_reset", {31'd0, bus.mem_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_vec("async_mem_write", {31'd0, bus.mem_write}, 32'd0);
    check_vec("async_state", {28'd0, bus.state_dbg}, 32'd0);
    check_vec("async_retired", bus.retired, 32'd0);
    exp_ret = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.opcode = 6'b000000;
    step("post_rst_fetch", 0, 1'b1, 1'b0);
    step("post_rst_decode", 1, 1'b1, 1'b0);
    step("post_rst_exec", 6, 1'b1, 1'b0);
    step("post_rst_aluwb", 7, 1'b1, 1'b1);
    step("post_rst_retired", 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
